// File: rtl/tron_pkg.sv
// ============================================================================
//  Module   : tron_pkg
//  Brief    : Shared board geometry, cell colours, address packing and FSM
//             state encoding for the game-board RAM clients.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tron_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] EMPTY = 3'b000;
    localparam logic [2:0] P1    = 3'b001;
    localparam logic [2:0] P2    = 3'b010;
    localparam logic [2:0] P3    = 3'b100;
    localparam logic [2:0] P4    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } render_state_t;

    function automatic logic [14:0] pack_addr(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
//  Module   : raster_counter
//  Brief    : Column-fastest raster position counter with last-cell flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [7:0] o_cx,
    output logic [6:0] o_cy,
    output logic       o_last
);

    localparam logic [7:0] c_XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] c_YMAX = 7'(HEIGHT - 1);

    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic       w_xwrap;

    assign w_xwrap = (r_cx == c_XMAX);
    assign o_last  = w_xwrap && (r_cy == c_YMAX);
    assign o_cx    = r_cx;
    assign o_cy    = r_cy;

    // After the last cell both counters wrap, so nothing off-screen is ever presented.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_en) begin
            if (w_xwrap) begin
                r_cx <= '0;
                r_cy <= (r_cy == c_YMAX) ? 7'd0 : r_cy + 7'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/board_renderer.sv
// ============================================================================
//  Module   : board_renderer
//  Brief    : Sweeps the game-board RAM in raster order and emits one plot
//             command per on-screen cell through a 2-stage read pipeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module board_renderer
    import tron_pkg::*;
#(
    parameter int WIDTH     = SCREEN_W,
    parameter int HEIGHT    = SCREEN_H,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        ram_gnt,
    output logic [14:0] ram_address,
    input  logic [2:0]  ram_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    render_state_t r_state, w_next;

    logic [7:0] w_cx;
    logic [6:0] w_cy;
    logic       w_last;
    logic       w_issue;
    logic       w_clr;

    logic       r_s1_valid;
    logic [7:0] r_s1_x;
    logic [6:0] r_s1_y;

    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;

    assign w_issue = (r_state == S_SCAN) && ram_gnt;
    assign w_clr   = (r_state == S_IDLE) && start;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk    (CLOCK_50),
        .rst    (reset),
        .i_en   (w_issue),
        .i_clr  (w_clr),
        .o_cx   (w_cx),
        .o_cy   (w_cy),
        .o_last (w_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Leaving DRAIN once stage 1 is empty: stage 2 retires its last cell on the
    // same edge, so done lands the cycle right after the final plot.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)            w_next = S_SCAN;
            S_SCAN:  if (w_issue && w_last) w_next = S_DRAIN;
            S_DRAIN: if (!r_s1_valid)      w_next = S_DONE;
            S_DONE:                        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_x <= w_cx;
                r_s1_y <= w_cy;
            end
            r_x      <= r_s1_x;
            r_y      <= r_s1_y;
            r_colour <= ram_q;
            r_plot   <= r_s1_valid && !(SKIP_ZERO && (ram_q == EMPTY));
        end
    end

    assign ram_address = (r_state == S_SCAN) ? pack_addr(w_cx, w_cy) : 15'd0;
    assign x           = r_x;
    assign y           = r_y;
    assign colour      = r_colour;
    assign plot        = r_plot;
    assign busy        = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_board_renderer.sv
// ============================================================================
//  Module   : tb_board_renderer
//  Brief    : Scoreboard bench for board_renderer: one instance with every cell
//             plotted, one with empty cells skipped, sharing clock and controls.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_renderer;

    logic clk;
    logic rst;
    logic start;
    logic gnt;

    logic [14:0] a0, a1;
    logic [2:0]  q0 = '0, q1 = '0;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [2:0]  c0, c1;
    logic        p0, p1, b0, b1, d0, d1;

    logic [2:0] mem0 [32768];
    logic [2:0] mem1 [32768];

    logic [17:0] sb0 [$];
    logic [17:0] sb1 [$];

    int n_checks = 0;
    int n_errors = 0;
    int plots0 = 0, plots1 = 0, dones0 = 0, dones1 = 0;
    logic pp0 = 1'b0, pp1 = 1'b0;
    logic [14:0] last_a1 = '0;
    logic gpat = 1'b0;
    int pat [6] = '{1, 1, 0, 0, 0, 1};

    board_renderer #(.WIDTH(160), .HEIGHT(120), .SKIP_ZERO(1'b0)) dut0 (
        .CLOCK_50 (clk), .reset (rst), .start (start), .ram_gnt (gnt),
        .ram_address (a0), .ram_q (q0), .x (x0), .y (y0), .colour (c0),
        .plot (p0), .busy (b0), .done (d0)
    );

    board_renderer #(.WIDTH(160), .HEIGHT(120), .SKIP_ZERO(1'b1)) dut1 (
        .CLOCK_50 (clk), .reset (rst), .start (start), .ram_gnt (gnt),
        .ram_address (a1), .ram_q (q1), .x (x1), .y (y1), .colour (c1),
        .plot (p1), .busy (b1), .done (d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        q0 <= mem0[a0];
        q1 <= mem1[a1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int k;
        k = 0;
        gnt = 1'b1;
        forever begin
            @(negedge clk);
            if (gpat) begin
                gnt = (pat[k] != 0);
                k = (k + 1) % 6;
            end else begin
                gnt = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (p0) begin
                if (sb0.size() == 0) check("plot0_unexpected", 32'(p0), 0);
                else                 check("plot0_cell", 32'({x0, y0, c0}), 32'(sb0.pop_front()));
                plots0++;
            end
            if (d0) begin
                dones0++;
                check("busy0_at_done", 32'(b0), 0);
                check("done0_after_last_plot", 32'(pp0), 1);
                check("done0_pending", sb0.size(), 0);
            end
            if (p1) begin
                if (sb1.size() == 0) check("plot1_unexpected", 32'(p1), 0);
                else                 check("plot1_cell", 32'({x1, y1, c1}), 32'(sb1.pop_front()));
                plots1++;
            end
            if (d1) begin
                dones1++;
                check("busy1_at_done", 32'(b1), 0);
                check("done1_after_last_plot", 32'(pp1), 1);
                check("done1_pending", sb1.size(), 0);
            end
            if (a1 != 15'd0) last_a1 = a1;
            pp0 = p0;
            pp1 = p1;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr0"}, 32'(a0), 0);
        check({tag, "_xyc0"},  32'({x0, y0, c0}), 0);
        check({tag, "_ctl0"},  32'({p0, b0, d0}), 0);
        check({tag, "_addr1"}, 32'(a1), 0);
        check({tag, "_xyc1"},  32'({x1, y1, c1}), 0);
        check({tag, "_ctl1"},  32'({p1, b1, d1}), 0);
    endtask

    task automatic clear_counts();
        plots0 = 0; plots1 = 0; dones0 = 0; dones1 = 0; last_a1 = '0;
    endtask

    // Expected stream for a full sweep, raster order with x fastest.
    task automatic start_sweep();
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                sb0.push_back({8'(xx), 7'(yy), mem0[15'((xx << 7) | yy)]});
                if (mem1[15'((xx << 7) | yy)] != 3'b000)
                    sb1.push_back({8'(xx), 7'(yy), mem1[15'((xx << 7) | yy)]});
            end
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy0_rises", 32'(b0), 1);
        check("busy1_rises", 32'(b1), 1);
    endtask

    task automatic wait_plots(input int n, input int limit);
        int k;
        k = 0;
        while (plots0 < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("wait_plots_timeout", 32'(plots0 >= n), 1);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while ((dones0 == 0 || dones1 == 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("wait_done_timeout", 32'(dones0 > 0 && dones1 > 0), 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_sweep_totals(input string tag);
        check({tag, "_dones0"}, dones0, 1);
        check({tag, "_dones1"}, dones1, 1);
        check({tag, "_plots0"}, plots0, 19200);
        check({tag, "_plots1"}, plots1, 2);
        check({tag, "_left0"}, sb0.size(), 0);
        check({tag, "_left1"}, sb1.size(), 0);
        check({tag, "_busy0_idle"}, 32'(b0), 0);
    endtask

    initial begin
        int saved;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            mem0[i] = 3'(((i >> 7) + (i & 127)) % 8);
            mem1[i] = 3'b000;
        end
        mem1[15'((5 << 7) | 7)]     = 3'b001;
        mem1[15'((159 << 7) | 119)] = 3'b110;

        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Start and reset together: reset must win.
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk);
        check("start_rst_busy0", 32'(b0), 0);
        check("start_rst_busy1", 32'(b1), 0);
        check("start_rst_plots", plots0 + plots1, 0);

        // Full sweep, gnt held high, second start pulsed mid-sweep.
        clear_counts();
        start_sweep();
        wait_plots(100, 1000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(25000);
        check_sweep_totals("full");
        check("last_addr_skip", 32'(last_a1), 20471);

        // Reset in the middle of a sweep.
        clear_counts();
        start_sweep();
        wait_plots(5000, 10000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sb0.delete();
        sb1.delete();
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saved = plots0;
        repeat (20) @(negedge clk);
        check("no_plot_after_reset", plots0, saved);
        check("idle_after_reset", 32'({b0, b1}), 0);

        // Restarted sweep with a gappy grant pattern.
        clear_counts();
        gpat = 1'b1;
        start_sweep();
        wait_done(45000);
        gpat = 1'b0;
        check_sweep_totals("gapped");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
